// File: rtl/collatz_range_sweep_if.sv
// Handshake bundle between the lab front end and the Collatz sweep engine.
// The front end (master) drives go/start; the engine (slave) returns done/count.
interface collatz_range_sweep_if #(
   parameter int unsigned DATA_BITS  = 32,
   parameter int unsigned COUNT_BITS = 16
);
   logic                  go;
   logic [DATA_BITS-1:0]  start;
   logic                  done;
   logic [COUNT_BITS-1:0] count;

   modport master (output go, output start, input done, input count);
   modport slave  (input go, input start, output done, output count);
endinterface

// File: rtl/collatz_range_sweep.sv
// Collatz range sweep engine: on go, computes sequence lengths for RAM_WORDS
// consecutive start values from a latched base, stores them in block RAM, then
// serves them as a read port (start = address, count = stored length).
// Optional build macro COLLATZ_SHORTCUT_EN folds each odd step with the
// following halving into one cycle; stored counts are unchanged.
module collatz_range_sweep #(
   parameter int unsigned RAM_WORDS     = 256,
   parameter int unsigned RAM_ADDR_BITS = 8,
   parameter int unsigned COUNT_BITS    = 16,
   parameter int unsigned DATA_BITS     = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   collatz_range_sweep_if.slave   bus
);

   localparam logic [COUNT_BITS-1:0]    ITER_MAX  = '1;
   localparam logic [RAM_ADDR_BITS-1:0] ADDR_LAST = RAM_ADDR_BITS'(RAM_WORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ITER,
      ST_WRITE,
      ST_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [DATA_BITS-1:0]     base_q,  base_d;
   logic [RAM_ADDR_BITS-1:0] addr_q,  addr_d;
   logic [DATA_BITS-1:0]     n_q,     n_d;
   logic [COUNT_BITS-1:0]    iter_q,  iter_d;
   logic                     done_q,  done_d;

   logic [DATA_BITS-1:0]     load_n_c;
   logic [DATA_BITS-1:0]     triple_c;
   logic                     ram_we_c;
   logic [RAM_ADDR_BITS-1:0] ram_addr_c;
   logic [COUNT_BITS-1:0]    ram_q;
   logic [COUNT_BITS-1:0]    ram [RAM_WORDS];

   // Start value of the current slot and the odd-step product, both modulo 2**DATA_BITS.
   assign load_n_c = base_q + DATA_BITS'(addr_q);
   assign triple_c = n_q + (n_q << 1) + DATA_BITS'(1);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         addr_q  <= '0;
         n_q     <= '0;
         iter_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         n_q     <= n_d;
         iter_q  <= iter_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath updates; go is only honoured in IDLE or DONE.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      addr_d  = addr_q;
      n_d     = n_q;
      iter_d  = iter_q;
      done_d  = done_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.go) begin
               base_d  = bus.start;
               addr_d  = '0;
               done_d  = 1'b0;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            n_d = load_n_c;
            if (load_n_c == '0) begin
               // Zero never reaches 1; record an empty sequence.
               iter_d  = '0;
               state_d = ST_WRITE;
            end else begin
               iter_d  = COUNT_BITS'(1);
               state_d = ST_ITER;
            end
         end

         ST_ITER: begin
            if (n_q == DATA_BITS'(1)) begin
               state_d = ST_WRITE;
            end else if (iter_q == ITER_MAX) begin
               // Saturated: store the ceiling rather than wrap.
               state_d = ST_WRITE;
            end else if (!n_q[0]) begin
               n_d    = n_q >> 1;
               iter_d = iter_q + COUNT_BITS'(1);
            end else begin
`ifdef COLLATZ_SHORTCUT_EN
               // 3n+1 is always even, so the halving that follows is folded in.
               n_d    = triple_c >> 1;
               iter_d = (iter_q >= (ITER_MAX - COUNT_BITS'(1))) ? ITER_MAX
                                                                  : iter_q + COUNT_BITS'(2);
`else
               n_d    = triple_c;
               iter_d = iter_q + COUNT_BITS'(1);
`endif
            end
         end

         ST_WRITE: begin
            if (addr_q == ADDR_LAST) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               addr_d  = addr_q + RAM_ADDR_BITS'(1);
               state_d = ST_LOAD;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Single RAM port: sweep slot while busy, external read address once done.
   assign ram_we_c   = (state_q == ST_WRITE);
   assign ram_addr_c = (state_q == ST_DONE) ? bus.start[RAM_ADDR_BITS-1:0] : addr_q;

   // Synchronous single-port RAM with registered read data (block RAM template).
   always_ff @(posedge clk) begin
      if (ram_we_c) begin
         ram[ram_addr_c] <= iter_q;
      end else begin
         ram_q <= ram[ram_addr_c];
      end
   end

   // Outputs: live counter while sweeping, RAM read data once done.
   assign bus.done  = done_q;
   assign bus.count = (state_q == ST_DONE) ? ram_q : iter_q;

endmodule

// File: tb/tb_collatz_range_sweep.sv
// Directed bench for collatz_range_sweep: reads back known sequence lengths,
// checks go-ignore while busy, mid-sweep reset, saturation with a narrow
// counter, and sweep latency (exact for the plain build, shorter with shortcut).
module tb_collatz_range_sweep;

   localparam int unsigned LIMIT = 40000;

   logic clk = 1'b0;
   logic rst_n;

   always #10 clk = ~clk;

   collatz_range_sweep_if #(.DATA_BITS(32), .COUNT_BITS(16)) bus ();
   collatz_range_sweep_if #(.DATA_BITS(32), .COUNT_BITS(4))  sat_bus ();

   collatz_range_sweep #(.COUNT_BITS(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   collatz_range_sweep #(.COUNT_BITS(4)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sat_bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc;
   int plain_cycles;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference sequence length (terms including n and the final 1).
   function automatic int unsigned clen(input int unsigned start_n);
      int unsigned n;
      int unsigned c;
      n = start_n;
      if (n == 0) return 0;
      c = 1;
      while (n != 1) begin
         if (n[0]) n = 3 * n + 1;
         else      n = n >> 1;
         c++;
      end
      return c;
   endfunction

   task automatic pulse_go(input logic [31:0] s, input bit also_sat);
      @(negedge clk);
      bus.start = s;
      bus.go    = 1'b1;
      if (also_sat) begin
         sat_bus.start = s;
         sat_bus.go    = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.go     = 1'b0;
      sat_bus.go = 1'b0;
   endtask

   task automatic wait_done(input bit sel, output int cycles);
      cycles = 0;
      while (((sel ? sat_bus.done : bus.done) !== 1'b1) && cycles < LIMIT) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      chk(sel ? "sat_timeout" : "timeout", 32'(cycles < LIMIT), 32'd1);
   endtask

   task automatic rd(input bit sel, input int unsigned a, input int unsigned exp, input string tag);
      @(negedge clk);
      if (sel) sat_bus.start = a;
      else     bus.start     = a;
      @(posedge clk);
      @(negedge clk);
      chk(tag, sel ? 32'(sat_bus.count) : 32'(bus.count), exp);
   endtask

   task automatic check_cycles(input string tag, input int cycles);
`ifdef COLLATZ_SHORTCUT_EN
      chk(tag, 32'(cycles < plain_cycles), 32'd1);
`else
      chk(tag, cycles, plain_cycles);
`endif
   endtask

   task automatic base1_reads(input string pfx);
      rd(0, 0,  1,   {pfx, "_a0"});
      rd(0, 1,  2,   {pfx, "_a1"});
      rd(0, 2,  8,   {pfx, "_a2"});
      rd(0, 6,  17,  {pfx, "_a6"});
      rd(0, 26, 112, {pfx, "_a26"});
   endtask

   initial begin
      plain_cycles = 0;
      for (int v = 1; v <= 256; v++) plain_cycles += int'(clen(v)) + 2;

      rst_n         = 1'b0;
      bus.go        = 1'b0;
      bus.start     = '0;
      sat_bus.go    = 1'b0;
      sat_bus.start = '0;
      #35;
      chk("rst_done",  32'(bus.done),  32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Base 1 on both engines.
      pulse_go(32'd1, 1'b1);
      chk("busy_done", 32'(bus.done), 32'd0);
      wait_done(0, cyc);
      check_cycles("sweep_cycles", cyc);
      base1_reads("b1");
      for (int a = 0; a < 256; a++) rd(0, a, clen(a + 1), "ram_b1");

      // Narrow counter saturates at 15.
      wait_done(1, cyc);
      rd(1, 26, 15, "sat_a26");
      rd(1, 6,  15, "sat_a6");
      rd(1, 0,  1,  "sat_a0");
      rd(1, 2,  8,  "sat_a2");

      // Base 0: slot 0 holds the empty sequence.
      pulse_go(32'd0, 1'b0);
      chk("done_fall", 32'(bus.done), 32'd0);
      wait_done(0, cyc);
      rd(0, 0, 0, "b0_a0");
      rd(0, 2, 2, "b0_a2");
      rd(0, 3, 8, "b0_a3");

      // A go while busy must not re-latch the base.
      pulse_go(32'd1, 1'b0);
      repeat (50) @(negedge clk);
      pulse_go(32'd100, 1'b0);
      wait_done(0, cyc);
      rd(0, 26, 112, "ign_a26");
      rd(0, 0,  1,   "ign_a0");

      // Reset mid-sweep, then a clean rerun.
      pulse_go(32'd1, 1'b0);
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_done",  32'(bus.done),  32'd0);
      chk("mid_rst_count", 32'(bus.count), 32'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_count_edge", 32'(bus.count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulse_go(32'd1, 1'b0);
      wait_done(0, cyc);
      check_cycles("rerun_cycles", cyc);
      base1_reads("rr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
